// File: rtl/regfile_load_sequencer_pkg.sv
// ============================================================================
// acc_ctrl_pkg : shared types and widths for the job load sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package acc_ctrl_pkg;

  localparam int ADDR_W  = 12;
  localparam int INEX_W  = 32;
  localparam int STATE_W = 18;
  localparam int CNT_W   = 16;
  localparam int NWR_W   = 13;

  localparam logic REGSEL_INEX  = 1'b0;
  localparam logic REGSEL_STATE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_load_sequencer_if.sv
// ============================================================================
// regfile_load_sequencer_if : host command, engine and regfile write-port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_load_sequencer_if
  import acc_ctrl_pkg::*;
;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_sel;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [INEX_W-1:0]  cmd_data;
  logic               cmd_last;
  logic               abort;
  logic               ack;
  logic               engine_done;

  logic               ran_we_InexRecur;
  logic [ADDR_W-1:0]  ran_w_addr_InexRecur;
  logic [INEX_W-1:0]  ran_w_data_InexRecur;
  logic               ran_we_state_external;
  logic [ADDR_W-1:0]  ran_w_addr_state_external;
  logic [STATE_W-1:0] ran_w_data_state_external;

  logic               is_start;
  logic               busy;
  logic               done;
  logic               err_addr;
  logic               err_timeout;
  logic [NWR_W-1:0]   n_written;

  modport master (
    output cmd_valid, cmd_sel, cmd_addr, cmd_data, cmd_last, abort, ack, engine_done,
    input  cmd_ready, ran_we_InexRecur, ran_w_addr_InexRecur, ran_w_data_InexRecur,
           ran_we_state_external, ran_w_addr_state_external, ran_w_data_state_external,
           is_start, busy, done, err_addr, err_timeout, n_written
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_addr, cmd_data, cmd_last, abort, ack, engine_done,
    output cmd_ready, ran_we_InexRecur, ran_w_addr_InexRecur, ran_w_data_InexRecur,
           ran_we_state_external, ran_w_addr_state_external, ran_w_data_state_external,
           is_start, busy, done, err_addr, err_timeout, n_written
  );

endinterface

`default_nettype wire

// File: rtl/regfile_load_sequencer_timeout_cnt.sv
// ============================================================================
// ctrl_timeout_cnt : loadable down-counter with zero flag (settle and run windows)
// Rev 1.0
// ============================================================================
`default_nettype none

module ctrl_timeout_cnt #(
  parameter int W = 16
) (
  input  wire          clk,
  input  wire          rst,
  input  wire          load_i,
  input  wire  [W-1:0] load_val_i,
  input  wire          en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/regfile_load_sequencer.sv
// ============================================================================
// regfile_load_sequencer : preloads both regfiles, waits, then runs one engine job
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_load_sequencer
  import acc_ctrl_pkg::*;
#(
  parameter int DEPTH         = 4096,
  parameter int SETTLE_CYCLES = 3,
  parameter int TIMEOUT       = 65535
) (
  input  wire                     clk,
  input  wire                     rst,
  regfile_load_sequencer_if.slave bus
);

  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] SETTLE_L  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT - 1);

  ctrl_state_e        state_q, state_d;
  logic               cmd_ready, accept, addr_ok, wr_fire, timeout_hit;
  logic               cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0]   cnt_val;

  logic               we_inex_q, we_state_q;
  logic [ADDR_W-1:0]  addr_inex_q, addr_state_q;
  logic [INEX_W-1:0]  data_inex_q;
  logic [STATE_W-1:0] data_state_q;

  logic               err_addr_q, err_addr_d;
  logic               err_timeout_q, err_timeout_d;
  logic [NWR_W-1:0]   n_written_q, n_written_d;

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign accept    = bus.cmd_valid && cmd_ready;
  assign addr_ok   = ({1'b0, bus.cmd_addr} < DEPTH_L);
  assign wr_fire   = accept && !bus.abort;

  ctrl_timeout_cnt #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_val     = SETTLE_L;
    cnt_en      = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          state_d  = bus.cmd_last ? ST_SETTLE : ST_LOAD;
          cnt_load = bus.cmd_last;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          state_d  = ST_RUN;
          cnt_load = 1'b1;
          cnt_val  = TIMEOUT_L;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RUN: begin
        // engine_done wins over a coincident timeout, so no error is flagged then
        if (bus.engine_done) begin
          state_d = ST_DONE;
        end else if (cnt_zero) begin
          state_d     = ST_DONE;
          timeout_hit = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.abort) state_d = ST_IDLE;
  end

  always_comb begin
    err_addr_d    = err_addr_q;
    err_timeout_d = err_timeout_q;
    n_written_d   = n_written_q;
    if (wr_fire) begin
      if (state_q == ST_IDLE) begin
        err_addr_d    = !addr_ok;
        err_timeout_d = 1'b0;
        n_written_d   = addr_ok ? NWR_W'(1) : '0;
      end else if (!addr_ok) begin
        err_addr_d = 1'b1;
      end else if (n_written_q != '1) begin
        n_written_d = n_written_q + 1'b1;
      end
    end
    if (timeout_hit && !bus.abort) err_timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_inex_q     <= 1'b0;
      we_state_q    <= 1'b0;
      addr_inex_q   <= '0;
      addr_state_q  <= '0;
      data_inex_q   <= '0;
      data_state_q  <= '0;
      err_addr_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      n_written_q   <= '0;
    end else begin
      we_inex_q     <= 1'b0;
      we_state_q    <= 1'b0;
      err_addr_q    <= err_addr_d;
      err_timeout_q <= err_timeout_d;
      n_written_q   <= n_written_d;
      if (wr_fire && addr_ok) begin
        if (bus.cmd_sel == REGSEL_INEX) begin
          we_inex_q   <= 1'b1;
          addr_inex_q <= bus.cmd_addr;
          data_inex_q <= bus.cmd_data;
        end else begin
          we_state_q   <= 1'b1;
          addr_state_q <= bus.cmd_addr;
          data_state_q <= bus.cmd_data[STATE_W-1:0];
        end
      end
    end
  end

  assign bus.cmd_ready                 = cmd_ready;
  assign bus.ran_we_InexRecur          = we_inex_q;
  assign bus.ran_w_addr_InexRecur      = addr_inex_q;
  assign bus.ran_w_data_InexRecur      = data_inex_q;
  assign bus.ran_we_state_external     = we_state_q;
  assign bus.ran_w_addr_state_external = addr_state_q;
  assign bus.ran_w_data_state_external = data_state_q;
  assign bus.is_start                  = (state_q == ST_RUN);
  assign bus.busy                      = (state_q != ST_IDLE);
  assign bus.done                      = (state_q == ST_DONE);
  assign bus.err_addr                  = err_addr_q;
  assign bus.err_timeout               = err_timeout_q;
  assign bus.n_written                 = n_written_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_load_sequencer.sv
// ============================================================================
// tb_regfile_load_sequencer : self-checking bench, write scoreboard plus job sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_load_sequencer;
  import acc_ctrl_pkg::*;

  localparam int DEPTH  = 16;
  localparam int SETTLE = 3;
  localparam int TMO    = 8;

  typedef struct packed {
    logic        sel;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        sel;
    logic [11:0] addr;
    logic [31:0] data;
    logic        last;
    logic [12:0] exp_n;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];

  always #5 clk = ~clk;

  regfile_load_sequencer_if bus();

  regfile_load_sequencer #(
    .DEPTH         (DEPTH),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT       (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Every observed write pulse must match the oldest expected write, one cycle each.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ran_we_InexRecur && bus.ran_we_state_external) begin
        fail_now("dual_we");
      end else if (bus.ran_we_InexRecur || bus.ran_we_state_external) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_sel", 32'(bus.ran_we_state_external), 32'(e.sel));
          check("wr_addr", 32'(bus.ran_we_state_external ? bus.ran_w_addr_state_external
                                                         : bus.ran_w_addr_InexRecur),
                32'(e.addr));
          check("wr_data", bus.ran_we_state_external ? 32'(bus.ran_w_data_state_external)
                                                     : bus.ran_w_data_InexRecur,
                e.sel ? {14'h0, e.data[17:0]} : e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sel, input logic [11:0] addr, input logic [31:0] data,
                      input logic last, input logic ab);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    bus.cmd_last  = last;
    bus.abort     = ab;
    check("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    if (!ab && (int'(addr) < DEPTH)) exp_q.push_back({sel, addr, data});
    tick();
  endtask

  task automatic idle_cmd();
    bus.cmd_valid = 1'b0;
    bus.cmd_last  = 1'b0;
    bus.abort     = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.is_start) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic finish_job(input logic [12:0] exp_n);
    bus.engine_done = 1'b1;
    tick();
    bus.engine_done = 1'b0;
    check("done_after_engine", 32'(bus.done), 32'd1);
    check("start_low_in_done", 32'(bus.is_start), 32'd0);
    check("n_written_done", 32'(bus.n_written), 32'(exp_n));
    check("no_timeout_err", 32'(bus.err_timeout), 32'd0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("idle_after_ack", 32'({bus.busy, bus.done}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    int   n;
    vecs[0] = '{1'b0, 12'h00F, 32'hA5A5_0F0F, 1'b0, 13'd1};
    vecs[1] = '{1'b1, 12'h001, 32'hFFFF_FFFF, 1'b0, 13'd2};
    vecs[2] = '{1'b0, 12'h002, 32'h1234_5678, 1'b0, 13'd3};
    vecs[3] = '{1'b1, 12'h003, 32'h0002_ABCD, 1'b1, 13'd4};

    bus.cmd_valid = 0; bus.cmd_sel = 0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.cmd_last = 0; bus.abort = 0; bus.ack = 0; bus.engine_done = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_flags", 32'({bus.busy, bus.done, bus.is_start, bus.err_addr, bus.err_timeout}), 32'd0);
    check("rst_we", 32'({bus.ran_we_InexRecur, bus.ran_we_state_external}), 32'd0);
    check("rst_n_written", 32'(bus.n_written), 32'd0);
    rst = 1'b0;

    // single job
    beat(REGSEL_INEX, 12'h000, 32'h0201_0006, 1'b0, 1'b0);
    check("busy_in_load", 32'(bus.busy), 32'd1);
    beat(REGSEL_STATE, 12'h000, 32'h0, 1'b1, 1'b0);
    idle_cmd();
    check("ready_low_settle", 32'(bus.cmd_ready), 32'd0);
    wait_start(n);
    check("settle_latency", 32'(n), 32'd4);
    tick();
    check("start_held", 32'(bus.is_start), 32'd1);
    finish_job(13'd2);

    // out-of-range address
    beat(REGSEL_INEX, 12'h010, 32'hDEAD_BEEF, 1'b1, 1'b0);
    idle_cmd();
    check("err_addr_set", 32'(bus.err_addr), 32'd1);
    check("oor_n_written", 32'(bus.n_written), 32'd0);
    wait_start(n);
    check("oor_settle_latency", 32'(n), 32'd4);
    finish_job(13'd0);

    // run timeout
    beat(REGSEL_STATE, 12'h004, 32'h0000_0155, 1'b1, 1'b0);
    idle_cmd();
    check("err_addr_cleared", 32'(bus.err_addr), 32'd0);
    wait_start(n);
    n = 0;
    while (bus.is_start && n < 20) begin
      n++;
      tick();
    end
    check("timeout_run_cycles", 32'(n), 32'(TMO));
    check("timeout_done", 32'(bus.done), 32'd1);
    check("timeout_err", 32'(bus.err_timeout), 32'd1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;

    // back-to-back table, then engine_done coinciding with the timeout
    for (int i = 0; i < 4; i++) begin
      beat(vecs[i].sel, vecs[i].addr, vecs[i].data, vecs[i].last, 1'b0);
      check("b2b_n_written", 32'(bus.n_written), 32'(vecs[i].exp_n));
      if (i == 0) check("err_timeout_cleared", 32'(bus.err_timeout), 32'd0);
    end
    idle_cmd();
    @(negedge clk);
    #1;
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    wait_start(n);
    check("b2b_settle_latency", 32'(n), 32'd4);
    repeat (TMO - 1) tick();
    check("start_last_run_cycle", 32'(bus.is_start), 32'd1);
    finish_job(13'd4);

    // abort in RUN
    beat(REGSEL_INEX, 12'h020, 32'h1111_1111, 1'b0, 1'b0);
    beat(REGSEL_STATE, 12'h003, 32'h000A_BCDE, 1'b1, 1'b0);
    idle_cmd();
    wait_start(n);
    tick();
    tick();
    check("start_before_abort", 32'(bus.is_start), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_start", 32'(bus.is_start), 32'd0);
    check("abort_busy_done", 32'({bus.busy, bus.done}), 32'd0);
    check("abort_keeps_err", 32'(bus.err_addr), 32'd1);
    check("abort_keeps_n", 32'(bus.n_written), 32'd1);
    repeat (3) tick();
    check("abort_no_done", 32'(bus.done), 32'd0);

    // new job after abort, then abort colliding with an accepted beat
    beat(REGSEL_INEX, 12'h005, 32'h5555_0005, 1'b0, 1'b0);
    check("new_job_err_cleared", 32'(bus.err_addr), 32'd0);
    check("new_job_n", 32'(bus.n_written), 32'd1);
    beat(REGSEL_INEX, 12'h006, 32'h6666_0006, 1'b0, 1'b1);
    idle_cmd();
    check("abort_accept_idle", 32'(bus.busy), 32'd0);
    check("abort_accept_n", 32'(bus.n_written), 32'd1);
    bus.engine_done = 1'b1;
    bus.ack         = 1'b1;
    tick();
    bus.engine_done = 1'b0;
    bus.ack         = 1'b0;
    check("stray_done_ack_ignored", 32'({bus.busy, bus.done, bus.is_start}), 32'd0);

    // reset mid-LOAD
    beat(REGSEL_INEX, 12'h007, 32'h0000_0077, 1'b0, 1'b0);
    idle_cmd();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("midrst_flags", 32'({bus.busy, bus.done, bus.is_start, bus.err_addr, bus.err_timeout}), 32'd0);
    check("midrst_we", 32'({bus.ran_we_InexRecur, bus.ran_we_state_external}), 32'd0);
    check("midrst_n", 32'(bus.n_written), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat(REGSEL_STATE, 12'h008, 32'hFFF3_0001, 1'b1, 1'b0);
    idle_cmd();
    check("fresh_job_n", 32'(bus.n_written), 32'd1);
    wait_start(n);
    check("fresh_settle_latency", 32'(n), 32'd4);
    finish_job(13'd1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
